// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlx_pkg
// Brief    : DLX opcode/func encodings, ALU op-code enum and decode helper.
// Revision : 1.0
// ============================================================================
package dlx_pkg;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SEQ = 4'd10,
        ALU_SLE = 4'd11,
        ALU_SLT = 4'd12,
        ALU_SNE = 4'd13,
        ALU_SRA = 4'd14
    } alu_op_e;

    localparam logic [5:0] c_op_rtype = 6'h00;

    localparam logic [5:0] c_func_add = 6'h20;
    localparam logic [5:0] c_func_sub = 6'h22;
    localparam logic [5:0] c_func_and = 6'h24;
    localparam logic [5:0] c_func_or  = 6'h25;
    localparam logic [5:0] c_func_xor = 6'h26;
    localparam logic [5:0] c_func_sll = 6'h04;
    localparam logic [5:0] c_func_srl = 6'h06;
    localparam logic [5:0] c_func_seq = 6'h28;
    localparam logic [5:0] c_func_sle = 6'h2C;
    localparam logic [5:0] c_func_slt = 6'h2A;
    localparam logic [5:0] c_func_sne = 6'h29;
    localparam logic [5:0] c_func_sra = 6'h07;

    localparam logic [5:0] c_op_addi = 6'h08;
    localparam logic [5:0] c_op_subi = 6'h0A;
    localparam logic [5:0] c_op_andi = 6'h0C;
    localparam logic [5:0] c_op_ori  = 6'h0D;
    localparam logic [5:0] c_op_xori = 6'h0E;
    localparam logic [5:0] c_op_slli = 6'h14;
    localparam logic [5:0] c_op_srli = 6'h16;
    localparam logic [5:0] c_op_seqi = 6'h18;
    localparam logic [5:0] c_op_slei = 6'h1C;
    localparam logic [5:0] c_op_slti = 6'h1A;
    localparam logic [5:0] c_op_snei = 6'h19;
    localparam logic [5:0] c_op_srai = 6'h17;

    typedef struct packed {
        alu_op_e op;
        logic    legal;
        logic    zext;
    } dec_t;

    // Logical immediates take a zero-extended operand, all others sign-extend.
    function automatic dec_t dlx_decode(input logic [5:0] opcode, input logic [5:0] func);
        dec_t d;
        d.op    = ALU_NOP;
        d.legal = 1'b1;
        d.zext  = 1'b0;
        if (opcode == c_op_rtype) begin
            case (func)
                c_func_add: d.op = ALU_ADD;
                c_func_sub: d.op = ALU_SUB;
                c_func_and: d.op = ALU_AND;
                c_func_or:  d.op = ALU_OR;
                c_func_xor: d.op = ALU_XOR;
                c_func_sll: d.op = ALU_SLL;
                c_func_srl: d.op = ALU_SRL;
                c_func_seq: d.op = ALU_SEQ;
                c_func_sle: d.op = ALU_SLE;
                c_func_slt: d.op = ALU_SLT;
                c_func_sne: d.op = ALU_SNE;
                c_func_sra: d.op = ALU_SRA;
                default:    d.legal = 1'b0;
            endcase
        end else begin
            case (opcode)
                c_op_addi: d.op = ALU_ADD;
                c_op_subi: d.op = ALU_SUB;
                c_op_andi: begin d.op = ALU_AND; d.zext = 1'b1; end
                c_op_ori:  begin d.op = ALU_OR;  d.zext = 1'b1; end
                c_op_xori: begin d.op = ALU_XOR; d.zext = 1'b1; end
                c_op_slli: d.op = ALU_SLL;
                c_op_srli: d.op = ALU_SRL;
                c_op_seqi: d.op = ALU_SEQ;
                c_op_slei: d.op = ALU_SLE;
                c_op_slti: d.op = ALU_SLT;
                c_op_snei: d.op = ALU_SNE;
                c_op_srai: d.op = ALU_SRA;
                default:   d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_if
// Brief    : Instruction, write-back and ALU issue bundle of the decode stage.
// Revision : 1.0
// ============================================================================
interface id_stage_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  alu_I;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic        alu_ex;
    logic [4:0]  rd_out;
    logic        rd_we_out;
    logic        illegal;

    modport master (
        output instr, instr_valid, wb_en, wb_addr, wb_data,
        input  instr_ready, alu_I, alu_op1, alu_op2, alu_ex, rd_out, rd_we_out, illegal
    );

    modport slave (
        input  instr, instr_valid, wb_en, wb_addr, wb_data,
        output instr_ready, alu_I, alu_op1, alu_op2, alu_ex, rd_out, rd_we_out, illegal
    );
endinterface
`default_nettype wire

// File: rtl/dlx_regfile.sv
`default_nettype none
// ============================================================================
// Module   : dlx_regfile
// Brief    : 32x32 register file, 2 read / 1 write, r0 hard zero, write bypass.
// Revision : 1.0
// ============================================================================
module dlx_regfile (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [4:0]  i_raddr1,
    input  wire logic [4:0]  i_raddr2,
    output logic      [31:0] o_rdata1,
    output logic      [31:0] o_rdata2,
    input  wire logic        i_we,
    input  wire logic [4:0]  i_waddr,
    input  wire logic [31:0] i_wdata
);

    logic [31:0] r_regs [0:31];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // A same-cycle write is forwarded so decode never sees a stale value.
    function automatic logic [31:0] read_port(input logic [4:0] a);
        if (a == 5'd0)
            return 32'd0;
        else if (i_we && (i_waddr == a))
            return i_wdata;
        else
            return r_regs[a];
    endfunction

    assign o_rdata1 = read_port(i_raddr1);
    assign o_rdata2 = read_port(i_raddr2);

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Brief    : DLX decode/issue stage with pending-write scoreboard interlock.
// Revision : 1.0
// ============================================================================
module id_stage
    import dlx_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    id_stage_if.slave  bus
);

    logic [5:0]  w_opcode;
    logic [5:0]  w_func;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_is_r;
    dec_t        w_dec;
    logic [31:0] w_imm;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;
    logic        w_haz1;
    logic        w_haz2;
    logic        w_hazard;
    logic        w_accept;
    logic        w_rd_we;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;

    logic [31:0] r_pending;
    logic        r_alu_ex;
    alu_op_e     r_alu_op;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [4:0]  r_rd;
    logic        r_rd_we;
    logic        r_illegal;

    assign w_opcode = bus.instr[31:26];
    assign w_func   = bus.instr[5:0];
    assign w_rs1    = bus.instr[25:21];
    assign w_rs2    = bus.instr[20:16];
    assign w_is_r   = (w_opcode == c_op_rtype);
    assign w_rd     = w_is_r ? bus.instr[15:11] : bus.instr[20:16];
    assign w_dec    = dlx_decode(w_opcode, w_func);
    assign w_imm    = w_dec.zext ? {16'd0, bus.instr[15:0]}
                                 : {{16{bus.instr[15]}}, bus.instr[15:0]};

    dlx_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (bus.wb_en),
        .i_waddr  (bus.wb_addr),
        .i_wdata  (bus.wb_data)
    );

    // A source retiring this very cycle is served by the regfile bypass.
    assign w_haz1 = w_dec.legal && (w_rs1 != 5'd0) && r_pending[w_rs1]
                    && !(bus.wb_en && (bus.wb_addr == w_rs1));
    assign w_haz2 = w_dec.legal && w_is_r && (w_rs2 != 5'd0) && r_pending[w_rs2]
                    && !(bus.wb_en && (bus.wb_addr == w_rs2));
    assign w_hazard = w_haz1 || w_haz2;

    assign bus.instr_ready = !w_hazard;
    assign w_accept        = bus.instr_valid && !w_hazard;
    assign w_rd_we         = w_dec.legal && (w_rd != 5'd0);

    assign w_set_mask = (w_accept && w_rd_we) ? (32'd1 << w_rd) : 32'd0;
    assign w_clr_mask = bus.wb_en ? (32'd1 << bus.wb_addr) : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_ex  <= 1'b0;
            r_alu_op  <= ALU_NOP;
            r_op1     <= '0;
            r_op2     <= '0;
            r_rd      <= '0;
            r_rd_we   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_alu_ex <= w_accept;
            if (w_accept) begin
                r_alu_op  <= w_dec.op;
                r_op1     <= w_rdata1;
                r_op2     <= w_is_r ? w_rdata2 : w_imm;
                r_rd      <= w_rd;
                r_rd_we   <= w_rd_we;
                r_illegal <= !w_dec.legal;
            end
        end
    end

    assign bus.alu_ex    = r_alu_ex;
    assign bus.alu_I     = r_alu_op;
    assign bus.alu_op1   = r_op1;
    assign bus.alu_op2   = r_op2;
    assign bus.rd_out    = r_rd;
    assign bus.rd_we_out = r_rd_we;
    assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Brief    : Directed self-checking bench for id_stage.
// Revision : 1.0
// ============================================================================
module tb_id_stage;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_issue(input string tag, input logic [3:0] op, input logic [31:0] op1,
                               input logic [31:0] op2, input logic [4:0] rd, input logic we);
        check({tag, ".alu_ex"},    {31'd0, bus.alu_ex},    32'd1);
        check({tag, ".alu_I"},     {28'd0, bus.alu_I},     {28'd0, op});
        check({tag, ".op1"},       bus.alu_op1,            op1);
        check({tag, ".op2"},       bus.alu_op2,            op2);
        check({tag, ".rd_out"},    {27'd0, bus.rd_out},    {27'd0, rd});
        check({tag, ".rd_we_out"}, {31'd0, bus.rd_we_out}, {31'd0, we});
        check({tag, ".illegal"},   {31'd0, bus.illegal},   32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".alu_ex"},    {31'd0, bus.alu_ex},    32'd0);
        check({tag, ".alu_I"},     {28'd0, bus.alu_I},     32'd0);
        check({tag, ".op1"},       bus.alu_op1,            32'd0);
        check({tag, ".op2"},       bus.alu_op2,            32'd0);
        check({tag, ".rd_out"},    {27'd0, bus.rd_out},    32'd0);
        check({tag, ".rd_we_out"}, {31'd0, bus.rd_we_out}, 32'd0);
        check({tag, ".illegal"},   {31'd0, bus.illegal},   32'd0);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input logic [5:0] func);
        return {6'h00, rs1, rs2, rd, 5'd0, func};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [15:0] imm);
        return {op, rs1, rd, imm};
    endfunction

    initial begin
        rst_n           = 1'b0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        tick();
        tick();
        check_zero("reset");
        check("reset.ready", {31'd0, bus.instr_ready}, 32'd1);

        // Preload r1=5, r2=7 through the write-back port
        rst_n       = 1'b1;
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd1;
        bus.wb_data = 32'd5;
        tick();
        bus.wb_addr = 5'd2;
        bus.wb_data = 32'd7;
        tick();
        bus.wb_en = 1'b0;
        check("idle.alu_ex", {31'd0, bus.alu_ex}, 32'd0);

        // ADD r3,r1,r2
        bus.instr       = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        bus.instr_valid = 1'b1;
        #1;
        check("add.ready", {31'd0, bus.instr_ready}, 32'd1);
        tick();
        check_issue("add", 4'd1, 32'd5, 32'd7, 5'd3, 1'b1);

        // SUB r5,r3,r1 stalls on pending r3
        bus.instr = rtype(5'd3, 5'd1, 5'd5, 6'h22);
        #1;
        check("sub.stall_ready0", {31'd0, bus.instr_ready}, 32'd0);
        tick();
        check("sub.stall_ex0", {31'd0, bus.alu_ex}, 32'd0);
        check("sub.stall_ready1", {31'd0, bus.instr_ready}, 32'd0);
        tick();
        check("sub.stall_ex1", {31'd0, bus.alu_ex}, 32'd0);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd3;
        bus.wb_data = 32'h10;
        #1;
        check("sub.wb_ready", {31'd0, bus.instr_ready}, 32'd1);
        tick();
        check_issue("sub", 4'd2, 32'h10, 32'd5, 5'd5, 1'b1);
        bus.wb_en = 1'b0;

        // Immediate extension, back-to-back issues
        bus.instr = itype(6'h0C, 5'd1, 5'd4, 16'hFFFF);
        tick();
        check_issue("andi", 4'd3, 32'd5, 32'h0000FFFF, 5'd4, 1'b1);
        bus.instr = itype(6'h08, 5'd1, 5'd4, 16'hFFFF);
        tick();
        check_issue("addi", 4'd1, 32'd5, 32'hFFFFFFFF, 5'd4, 1'b1);
        bus.instr = rtype(5'd1, 5'd2, 5'd7, 6'h07);
        tick();
        check_issue("sra", 4'd14, 32'd5, 32'd7, 5'd7, 1'b1);
        bus.instr = itype(6'h1A, 5'd3, 5'd8, 16'h8000);
        tick();
        check_issue("slti", 4'd12, 32'h10, 32'hFFFF8000, 5'd8, 1'b1);

        // Illegal opcode 0x3F targeting r9
        bus.instr = itype(6'h3F, 5'd1, 5'd9, 16'h0000);
        tick();
        check("ill.alu_ex",    {31'd0, bus.alu_ex},    32'd1);
        check("ill.alu_I",     {28'd0, bus.alu_I},     32'd0);
        check("ill.illegal",   {31'd0, bus.illegal},   32'd1);
        check("ill.rd_we_out", {31'd0, bus.rd_we_out}, 32'd0);
        bus.instr = rtype(5'd9, 5'd0, 5'd10, 6'h20);
        #1;
        check("ill.no_pending", {31'd0, bus.instr_ready}, 32'd1);
        tick();
        check_issue("after_ill", 4'd1, 32'd0, 32'd0, 5'd10, 1'b1);

        // rd = r0 never claims a write
        bus.instr = rtype(5'd1, 5'd2, 5'd0, 6'h20);
        tick();
        check_issue("rd0", 4'd1, 32'd5, 32'd7, 5'd0, 1'b0);

        // Write to r0 is neither stored nor bypassed
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'hDEAD;
        bus.instr   = rtype(5'd0, 5'd1, 5'd11, 6'h20);
        tick();
        check_issue("r0_bypass", 4'd1, 32'd0, 32'd5, 5'd11, 1'b1);
        bus.wb_en = 1'b0;
        bus.instr = rtype(5'd0, 5'd0, 5'd12, 6'h25);
        tick();
        check_issue("r0_read", 4'd4, 32'd0, 32'd0, 5'd12, 1'b1);

        // Same-cycle set and clear of r13 leaves it pending
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd13;
        bus.wb_data = 32'h99;
        bus.instr   = rtype(5'd1, 5'd2, 5'd13, 6'h20);
        tick();
        check_issue("setclr.issue", 4'd1, 32'd5, 32'd7, 5'd13, 1'b1);
        bus.wb_en = 1'b0;
        bus.instr = rtype(5'd13, 5'd0, 5'd14, 6'h20);
        #1;
        check("setclr.ready", {31'd0, bus.instr_ready}, 32'd0);
        tick();
        check("setclr.ex", {31'd0, bus.alu_ex}, 32'd0);
        bus.wb_en   = 1'b1;
        bus.wb_data = 32'h77;
        #1;
        check("setclr.wb_ready", {31'd0, bus.instr_ready}, 32'd1);
        tick();
        check_issue("setclr.done", 4'd1, 32'h77, 32'd0, 5'd14, 1'b1);
        bus.wb_en = 1'b0;

        // No valid: strobe drops, payload holds
        bus.instr_valid = 1'b0;
        tick();
        check("hold.alu_ex", {31'd0, bus.alu_ex},  32'd0);
        check("hold.alu_I",  {28'd0, bus.alu_I},   32'd1);
        check("hold.op1",    bus.alu_op1,          32'h77);

        // Reset with r3 pending and in-flight traffic
        bus.instr_valid = 1'b1;
        bus.instr       = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        tick();
        check_issue("pre_rst", 4'd1, 32'd5, 32'd7, 5'd3, 1'b1);
        rst_n       = 1'b0;
        bus.instr   = rtype(5'd3, 5'd1, 5'd5, 6'h22);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd11;
        bus.wb_data = 32'h55;
        tick();
        check_zero("rst2");
        rst_n     = 1'b1;
        bus.wb_en = 1'b0;
        #1;
        check("rst2.ready", {31'd0, bus.instr_ready}, 32'd1);
        tick();
        check_issue("post_rst", 4'd2, 32'd0, 32'd0, 5'd5, 1'b1);
        bus.instr = rtype(5'd11, 5'd0, 5'd15, 6'h20);
        tick();
        check_issue("rst_wb_ignored", 4'd1, 32'd0, 32'd0, 5'd15, 1'b1);
        bus.instr_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
